// File: rtl/kraken_dma_pkg.sv
// Shared types and defaults for the data-cache DMA responder.
package kraken_dma_pkg;

  localparam int unsigned DMA_LINE_WORDS = 16;

  typedef enum logic [1:0] {
    DMA_NONE = 2'b00,
    DMA_RD   = 2'b01,
    DMA_WR   = 2'b10
  } dma_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } dma_state_t;

endpackage

// File: rtl/dcache_dma_ctrl.sv
// Memory-side DMA responder for the data cache: turns one line fill or line
// writeback request into LINE_WORDS word transfers on the memory bus.
module dcache_dma_ctrl
  import kraken_dma_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DMA_LINE_WORDS,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 dma_mode,
  input  logic [ADDR_W-1:0]          dma_addr,
  input  logic [31:0]                dma_wr_data,
  output logic                       dma_wr_pop,
  output logic [LINE_WORDS-1:0][31:0] dma_data,
  output logic                       dma_done,
  output logic                       dma_busy,
  output logic                       dma_err,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [31:0]                mem_rdata
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0]     FULL     = CW'(LINE_WORDS);
  localparam logic [CW-1:0]     LAST     = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

  dma_state_t        state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     iss_cnt, rcv_cnt;
  logic              accept;

  assign accept = mem_req & mem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dma_mode == DMA_RD)      state_nx = READ;
        else if (dma_mode == DMA_WR) state_nx = WRITE;
      end
      READ:    if (mem_rvalid && rcv_cnt == LAST) state_nx = DONE;
      WRITE:   if (accept && iss_cnt == LAST)     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters restart every IDLE cycle so a new transaction always begins at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base     <= '0;
      iss_cnt  <= '0;
      rcv_cnt  <= '0;
      dma_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          iss_cnt <= '0;
          rcv_cnt <= '0;
          if (dma_mode == DMA_RD || dma_mode == DMA_WR) base <= dma_addr & ~OFF_MASK;
        end
        READ, WRITE: begin
          if (accept) iss_cnt <= iss_cnt + CW'(1);
          if (state == READ && mem_rvalid) begin
            dma_data[rcv_cnt[IW-1:0]] <= mem_rdata;
            rcv_cnt                   <= rcv_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dma_busy  = 1'b0;
    dma_done  = 1'b0;
    dma_err   = 1'b0;
    case (state)
      IDLE:  dma_err = (dma_mode == 2'b11);
      READ: begin
        dma_busy = 1'b1;
        mem_req  = (iss_cnt < FULL);
      end
      WRITE: begin
        dma_busy  = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = dma_wr_data;
      end
      default: dma_done = 1'b1;
    endcase
    if (mem_req) mem_addr = base + ADDR_W'({iss_cnt, 2'b00});
    dma_wr_pop = mem_req & mem_we & mem_gnt;
  end

endmodule
